// File: rtl/mandelbrot_lane_scheduler.sv
// Frame scheduler for LANES Mandelbrot point generators, with an ordered output FIFO.
// Optional perf_cycles/perf_stall counters are enabled by defining MANDEL_SCHED_PERF_EN.
module mandelbrot_lane_scheduler #(
  parameter int LANES      = 4,
  parameter int ITER_W     = 32,
  parameter int COORD_W    = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     SYS_RESET_N,
  input  logic                     start_render,
  input  logic                     abort,
  input  logic [COORD_W-1:0]       x_size,
  input  logic [COORD_W-1:0]       y_size,
  output logic [LANES-1:0]         lane_start,
  output logic [LANES*COORD_W-1:0] lane_x,
  output logic [LANES*COORD_W-1:0] lane_y,
  input  logic [LANES-1:0]         lane_done,
  input  logic [LANES*ITER_W-1:0]  lane_iter,
  output logic [ITER_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_eol,
  output logic                     out_eof,
  output logic                     busy,
  output logic                     frame_done
`ifdef MANDEL_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_cycles,
  output logic [15:0]              perf_stall
`endif
);

  localparam int TOT_W = 2 * COORD_W;
  localparam int IDX_W = TOT_W + 1;
  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int FA_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = ITER_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t               state, state_nxt;
  logic [COORD_W-1:0]   x_sz;
  logic [TOT_W-1:0]     total, index;
  logic [COORD_W-1:0]   cx [LANES];
  logic [COORD_W-1:0]   cy [LANES];
  logic [COORD_W-1:0]   nx [LANES];
  logic [COORD_W-1:0]   ny [LANES];
  logic [ITER_W-1:0]    result [LANES];
  logic [PTR_W-1:0]     ptr;
  logic                 armed;
  logic [LANES-1:0]     active;
  logic                 all_done, start_ok, run_abort;
  logic                 push, pop, fifo_full, fifo_empty;
  logic                 last_lane, final_round, push_eol, push_eof;
  logic [IDX_W-1:0]     index_w, total_w, pix_w;
  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [FA_W:0]        wr_ptr, rd_ptr;
  logic [ENT_W-1:0]     head;

  // Round bookkeeping: which lanes carry real pixels and where the drain pointer sits.
  always_comb begin
    index_w     = {1'b0, index};
    total_w     = {1'b0, total};
    pix_w       = index_w + IDX_W'(ptr);
    active      = '0;
    for (int i = 0; i < LANES; i++) begin
      active[i] = (index_w + IDX_W'(i)) < total_w;
    end
    all_done    = &(lane_done | ~active);
    start_ok    = start_render && (x_size >= COORD_W'(LANES)) && (y_size != '0);
    run_abort   = abort && (state != S_IDLE);
    fifo_empty  = (wr_ptr == rd_ptr);
    fifo_full   = (wr_ptr[FA_W] != rd_ptr[FA_W]) &&
                  (wr_ptr[FA_W-1:0] == rd_ptr[FA_W-1:0]);
    pop         = !fifo_empty && out_ready;
    push        = (state == S_DRAIN) && !abort && (!fifo_full || out_ready);
    last_lane   = (ptr == PTR_W'(LANES - 1)) || ((pix_w + IDX_W'(1)) >= total_w);
    final_round = (index_w + IDX_W'(LANES)) >= total_w;
    push_eol    = (cx[ptr] == x_sz - COORD_W'(1));
    push_eof    = (pix_w == total_w - IDX_W'(1));
    frame_done  = push && last_lane && final_round;
  end

  // Next coordinates: x_size >= LANES guarantees one wrap at most per round.
  always_comb begin
    logic [COORD_W:0] sum;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = {1'b0, cx[i]} + (COORD_W+1)'(LANES);
      if (sum >= {1'b0, x_sz}) begin
        nx[i] = COORD_W'(sum - {1'b0, x_sz});
        ny[i] = cy[i] + COORD_W'(1);
      end else begin
        nx[i] = sum[COORD_W-1:0];
        ny[i] = cy[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (armed && all_done) state_nxt = S_DRAIN;
      S_DRAIN: if (push && last_lane) state_nxt = final_round ? S_IDLE : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
    if (run_abort) state_nxt = S_IDLE;
  end

  // armed blocks the first WAIT cycle, when lanes may still show the previous done level.
  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      x_sz  <= '0;
      total <= '0;
      index <= '0;
      ptr   <= '0;
      armed <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        cx[i]     <= '0;
        cy[i]     <= '0;
        result[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: if (start_ok) begin
          x_sz  <= x_size;
          total <= TOT_W'(x_size) * TOT_W'(y_size);
          index <= '0;
          for (int i = 0; i < LANES; i++) begin
            cx[i] <= COORD_W'(i);
            cy[i] <= '0;
          end
        end
        S_ISSUE: armed <= 1'b0;
        S_WAIT: begin
          armed <= 1'b1;
          if (armed && all_done) begin
            ptr <= '0;
            for (int i = 0; i < LANES; i++) begin
              if (active[i]) result[i] <= lane_iter[i*ITER_W +: ITER_W];
            end
          end
        end
        S_DRAIN: if (push) begin
          ptr <= ptr + PTR_W'(1);
          if (last_lane && !final_round) begin
            index <= index + TOT_W'(LANES);
            for (int i = 0; i < LANES; i++) begin
              cx[i] <= nx[i];
              cy[i] <= ny[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (run_abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (FA_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (FA_W+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[FA_W-1:0]] <= {push_eof, push_eol, result[ptr]};
  end

  always_comb begin
    head       = mem[rd_ptr[FA_W-1:0]];
    out_valid  = !fifo_empty;
    out_data   = out_valid ? head[ITER_W-1:0] : '0;
    out_eol    = out_valid && head[ITER_W];
    out_eof    = out_valid && head[ITER_W+1];
    busy       = (state != S_IDLE);
    lane_start = (state == S_ISSUE) ? active : '0;
    lane_x     = '0;
    lane_y     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_x[i*COORD_W +: COORD_W] = cx[i];
      lane_y[i*COORD_W +: COORD_W] = cy[i];
    end
  end

`ifdef MANDEL_SCHED_PERF_EN
  // Stall means a full FIFO with no pop to make room this cycle.
  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == S_IDLE) begin
      if (start_ok) begin
        perf_cycles <= '0;
        perf_stall  <= '0;
      end
    end else begin
      if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if ((state == S_DRAIN) && fifo_full && !out_ready && (perf_stall != '1))
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mandelbrot_lane_scheduler.sv
// Randomised self-checking bench: lane models with stale done levels, raster-order
// reference queue, stall/abort/reset/back-to-back scenarios.
module tb_mandelbrot_lane_scheduler;

  localparam int LANES      = 4;
  localparam int ITER_W     = 32;
  localparam int COORD_W    = 11;
  localparam int FIFO_DEPTH = 16;
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  logic                     CLK = 1'b0;
  logic                     SYS_RESET_N;
  logic                     start_render, abort;
  logic [COORD_W-1:0]       x_size, y_size;
  logic [LANES-1:0]         lane_start;
  logic [LANES*COORD_W-1:0] lane_x, lane_y;
  logic [LANES-1:0]         lane_done;
  logic [LANES*ITER_W-1:0]  lane_iter;
  logic [ITER_W-1:0]        out_data;
  logic                     out_valid, out_ready, out_eol, out_eof, busy, frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_cnt   = 0;
  int rnd      = 0;
  int cur_xs   = 1;
  int cur_total = 0;
  int ready_mode = 0;
  bit rand_lat = 1'b0;
  int lat_cfg [LANES];
  logic [7:0] salt = 8'd0;
  logic [ITER_W+1:0] exp_q [$];

  logic [LANES-1:0]   done_r, pend;
  logic [ITER_W-1:0]  iter_r [LANES];
  int                 cnt [LANES];
  logic [COORD_W-1:0] lx [LANES];
  logic [COORD_W-1:0] ly [LANES];

  always #5 CLK = ~CLK;

  mandelbrot_lane_scheduler #(
    .LANES(LANES), .ITER_W(ITER_W), .COORD_W(COORD_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(CLK), .SYS_RESET_N(SYS_RESET_N), .start_render(start_render), .abort(abort),
    .x_size(x_size), .y_size(y_size), .lane_start(lane_start), .lane_x(lane_x),
    .lane_y(lane_y), .lane_done(lane_done), .lane_iter(lane_iter), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .frame_done(frame_done)
  );

  function automatic logic [31:0] pix_val(input int x, input int y, input logic [7:0] s);
    logic [10:0] xv, yv;
    xv = 11'(x);
    yv = 11'(y);
    return {s, 2'b00, yv, xv};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Lane model: done drops one cycle after the start pulse, so the first WAIT cycle sees a stale level.
  assign lane_done = done_r;
  always_comb begin
    for (int i = 0; i < LANES; i++) lane_iter[i*ITER_W +: ITER_W] = iter_r[i];
  end

  always @(posedge CLK) begin
    if (!SYS_RESET_N) begin
      done_r <= '1;
      pend   <= '0;
      for (int i = 0; i < LANES; i++) begin
        iter_r[i] <= POISON;
        cnt[i]    <= 0;
        lx[i]     <= '0;
        ly[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_start[i]) begin
          pend[i] <= 1'b1;
          lx[i]   <= lane_x[i*COORD_W +: COORD_W];
          ly[i]   <= lane_y[i*COORD_W +: COORD_W];
        end else if (pend[i]) begin
          pend[i]   <= 1'b0;
          done_r[i] <= 1'b0;
          iter_r[i] <= POISON;
          cnt[i]    <= rand_lat ? int'($urandom_range(1, 8)) : lat_cfg[i];
        end else if (cnt[i] != 0) begin
          cnt[i] <= cnt[i] - 1;
          if (cnt[i] == 1) begin
            done_r[i] <= 1'b1;
            iter_r[i] <= pix_val(int'(lx[i]), int'(ly[i]), salt);
          end
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: issued coordinates against the raster, outputs against the reference queue.
  initial begin
    logic [ITER_W+1:0] e;
    int p;
    forever begin
      @(negedge CLK);
      if (SYS_RESET_N) begin
        if (frame_done) fd_cnt++;
        if (lane_start != '0) begin
          for (int i = 0; i < LANES; i++) begin
            p = rnd * LANES + i;
            checkOutput("start_mask", lane_start[i], (p < cur_total));
            if (p < cur_total) begin
              checkOutput("lane_x", lane_x[i*COORD_W +: COORD_W], p % cur_xs);
              checkOutput("lane_y", lane_y[i*COORD_W +: COORD_W], p / cur_xs);
            end
          end
          rnd++;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("out_data", out_data, e[ITER_W-1:0]);
            checkOutput("out_eol", out_eol, e[ITER_W]);
            checkOutput("out_eof", out_eof, e[ITER_W+1]);
          end
        end
      end
    end
  end

  task automatic buildExpected(input int xs, input int ys);
    int t;
    t = xs * ys;
    for (int p = 0; p < t; p++)
      exp_q.push_back({(p == t - 1), ((p % xs) == xs - 1), pix_val(p % xs, p / xs, salt)});
  endtask

  task automatic applyStimulus(input int xs, input int ys);
    salt = salt + 8'd1;
    cur_xs = xs;
    cur_total = xs * ys;
    rnd = 0;
    buildExpected(xs, ys);
    @(posedge CLK); #1;
    x_size = COORD_W'(xs);
    y_size = COORD_W'(ys);
    start_render = 1'b1;
    @(posedge CLK); #1;
    start_render = 1'b0;
  endtask

  task automatic waitFrame(input int target, input int budget);
    int n;
    n = 0;
    while ((fd_cnt < target || exp_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("frame_timeout", (n < budget), 1);
    checkOutput("frame_done_cnt", fd_cnt, target);
    checkOutput("busy_after_frame", busy, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_lane_start"}, lane_start, 0);
    checkOutput({tag, "_lane_x"}, lane_x, 0);
    checkOutput({tag, "_lane_y"}, lane_y, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_out_eol"}, out_eol, 0);
    checkOutput({tag, "_out_eof"}, out_eof, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    int base, n;
    logic [ITER_W+1:0] hd;
    SYS_RESET_N = 1'b0;
    start_render = 1'b0;
    abort = 1'b0;
    x_size = '0;
    y_size = '0;
    for (int i = 0; i < LANES; i++) lat_cfg[i] = 5;
    repeat (3) @(negedge CLK);
    checkResetOutputs("reset");
    @(posedge CLK); #1;
    SYS_RESET_N = 1'b1;

    $display("[TB] 8x2 frame, fixed latency 5");
    applyStimulus(8, 2);
    waitFrame(1, 500);
    checkOutput("rounds_8x2", rnd, 4);

    $display("[TB] 6x1 partial final round");
    applyStimulus(6, 1);
    waitFrame(2, 500);
    checkOutput("rounds_6x1", rnd, 2);

    $display("[TB] lane 3 skewed to 40 cycles");
    lat_cfg[3] = 40;
    for (int i = 0; i < 3; i++) lat_cfg[i] = 3;
    applyStimulus(8, 1);
    waitFrame(3, 500);

    $display("[TB] invalid sizes are ignored");
    @(posedge CLK); #1;
    x_size = COORD_W'(LANES - 1);
    y_size = 11'd2;
    start_render = 1'b1;
    @(posedge CLK); #1;
    x_size = 11'd8;
    y_size = 11'd0;
    @(negedge CLK);
    checkOutput("busy_small_x", busy, 0);
    @(posedge CLK); #1;
    start_render = 1'b0;
    @(negedge CLK);
    checkOutput("busy_zero_y", busy, 0);

    $display("[TB] output stall with full FIFO, 64 pixels");
    for (int i = 0; i < LANES; i++) lat_cfg[i] = 2;
    ready_mode = 2;
    applyStimulus(16, 4);
    repeat (100) @(negedge CLK);
    hd = exp_q[0];
    checkOutput("stall_valid", out_valid, 1);
    checkOutput("stall_busy", busy, 1);
    checkOutput("stall_head", out_data, hd[ITER_W-1:0]);
    checkOutput("stall_no_done", fd_cnt, 3);
    ready_mode = 0;
    waitFrame(4, 1000);

    $display("[TB] abort during round 2 wait");
    for (int i = 0; i < LANES; i++) lat_cfg[i] = 20;
    applyStimulus(8, 2);
    n = 0;
    while (rnd < 2 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("abort_reach_round2", (n < 500), 1);
    @(posedge CLK); #1;
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    @(negedge CLK);
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_busy", busy, 0);
    repeat (30) @(negedge CLK);
    checkOutput("abort_no_done", fd_cnt, 4);
    exp_q.delete();
    for (int i = 0; i < LANES; i++) lat_cfg[i] = 4;
    applyStimulus(8, 2);
    waitFrame(5, 500);

    $display("[TB] start_render held across frame_done");
    rand_lat = 1'b1;
    ready_mode = 1;
    base = fd_cnt;
    salt = salt + 8'd1;
    cur_xs = 5;
    cur_total = 10;
    rnd = 0;
    buildExpected(5, 2);
    @(posedge CLK); #1;
    x_size = 11'd5;
    y_size = 11'd2;
    start_render = 1'b1;
    n = 0;
    while (!frame_done && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("b2b_first_done", (n < 2000), 1);
    salt = salt + 8'd1;
    rnd = 0;
    buildExpected(5, 2);
    @(posedge CLK); #1;
    @(negedge CLK);
    checkOutput("b2b_idle_gap", busy, 0);
    @(posedge CLK); #1;
    start_render = 1'b0;
    @(negedge CLK);
    checkOutput("b2b_restart", busy, 1);
    waitFrame(base + 2, 3000);

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      applyStimulus(int'($urandom_range(LANES, 13)), int'($urandom_range(1, 4)));
      waitFrame(fd_cnt + 1, 5000);
    end

    $display("[TB] async reset during stalled drain");
    rand_lat = 1'b0;
    ready_mode = 2;
    applyStimulus(16, 4);
    repeat (40) @(negedge CLK);
    @(posedge CLK); #3;
    SYS_RESET_N = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    repeat (2) @(posedge CLK);
    exp_q.delete();
    rnd = 0;
    cur_total = 0;
    ready_mode = 0;
    #1;
    SYS_RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("post_reset_empty", out_valid, 0);
    checkOutput("post_reset_busy", busy, 0);
    base = fd_cnt;
    applyStimulus(6, 2);
    waitFrame(base + 1, 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
